// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, control-bundle bit positions and ID/EX payload type for the MIPS-lite core.
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int CTRL_W = 8;
  localparam int CTRL_REGDST = 7;
  localparam int CTRL_ALUSRC = 6;
  localparam int CTRL_MEMREAD = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_ALUOP = 0;
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } occ_e;
  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [5:0]            funct;
    logic [DEF_DATA_W-1:0] rd1;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] immed;
    logic [DEF_REG_AW-1:0] rs;
    logic [DEF_REG_AW-1:0] rt;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_REG_AW-1:0] shamt;
  } id_ex_payload_t;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one payload register with its valid bit; payload changes only on ld.
module pipe_skid_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         v_d,
  input  logic [W-1:0] d,
  output logic         v,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      q <= '0;
    end else begin
      v <= v_d;
      if (ld) q <= d;
    end
  end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: elastic ID->EX register with 2-entry skid buffer, flush, side-effect gating and bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W = mips_pkg::DEF_DATA_W,
  parameter int REG_AW = mips_pkg::DEF_REG_AW,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_immed,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_shamt,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [5:0]        out_funct,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_immed,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_shamt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import mips_pkg::*;
  localparam int PW = CTRL_W + 6 + 3 * DATA_W + 4 * REG_AW;
  localparam logic [CTRL_W-1:0] SIDE_FX = (CTRL_W'(1) << CTRL_MEMREAD) |
                                          (CTRL_W'(1) << CTRL_MEMWRITE) |
                                          (CTRL_W'(1) << CTRL_REGWRITE);
  logic          main_v, skid_v, main_ld, skid_ld, push, pop;
  logic [PW-1:0] in_p, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;
  occ_e          st, nxt;
  assign in_p = {in_ctrl, in_funct, in_rd1, in_rd2, in_immed, in_rs, in_rt, in_rd, in_shamt};
  assign st = occ_e'({main_v, skid_v});
  // in_ready comes straight from the skid flop, so EX stalls never reach ID combinationally
  assign in_ready = ~skid_v;
  assign out_valid = main_v;
  assign push = in_valid & in_ready;
  assign pop = main_v & out_ready;
  assign main_d = skid_v ? skid_q : in_p;
  always_comb begin
    nxt = st;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    case (st)
      EMPTY: begin
        nxt = push ? ONE : EMPTY;
        main_ld = push;
      end
      ONE: begin
        nxt = (push & ~pop) ? FULL : (~push & pop) ? EMPTY : ONE;
        main_ld = push & pop;
        skid_ld = push & ~pop;
      end
      FULL: begin
        nxt = pop ? ONE : FULL;
        main_ld = pop;
      end
      default: nxt = EMPTY;
    endcase
    if (flush) begin
      nxt = EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end
  pipe_skid_entry #(.W(PW)) u_main (
    .clk(clk), .rst(rst), .ld(main_ld), .v_d(nxt[1]), .d(main_d), .v(main_v), .q(main_q)
  );
  pipe_skid_entry #(.W(PW)) u_skid (
    .clk(clk), .rst(rst), .ld(skid_ld), .v_d(nxt[0]), .d(in_p), .v(skid_v), .q(skid_q)
  );
  assign {main_ctrl, out_funct, out_rd1, out_rd2, out_immed, out_rs, out_rt, out_rd, out_shamt} = main_q;
  assign out_ctrl = main_v ? main_ctrl : main_ctrl & ~SIDE_FX;
  always_ff @(posedge clk) begin
    if (rst) bubble_cnt <= '0;
    else if (!main_v && bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed vector table plus hand sequences for reset, flush and counter saturation.
module tb_id_ex_pipe_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, flush, out_ready;
  logic [7:0] in_ctrl;
  logic [5:0] in_funct;
  logic [31:0] in_rd1, in_rd2, in_immed;
  logic [4:0] in_rs, in_rt, in_rd, in_shamt;
  logic in_ready, out_valid;
  logic [7:0] out_ctrl;
  logic [5:0] out_funct;
  logic [31:0] out_rd1, out_rd2, out_immed;
  logic [4:0] out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] bubble_cnt;
  logic s_in_ready, s_out_valid;
  logic [7:0] s_out_ctrl;
  logic [5:0] s_out_funct;
  logic [31:0] s_out_rd1, s_out_rd2, s_out_immed;
  logic [4:0] s_out_rs, s_out_rt, s_out_rd, s_out_shamt;
  logic [3:0] s_cnt;
  int checks = 0, failures = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_funct(in_funct), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_immed(in_immed),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_ctrl(out_ctrl), .out_funct(out_funct),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_immed(out_immed), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .bubble_cnt(bubble_cnt)
  );
  id_ex_pipe_reg #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl),
    .in_funct(in_funct), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_immed(in_immed),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .flush(flush),
    .out_ready(out_ready), .out_valid(s_out_valid), .out_ctrl(s_out_ctrl), .out_funct(s_out_funct),
    .out_rd1(s_out_rd1), .out_rd2(s_out_rd2), .out_immed(s_out_immed), .out_rs(s_out_rs),
    .out_rt(s_out_rt), .out_rd(s_out_rd), .out_shamt(s_out_shamt), .bubble_cnt(s_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        fl;
    logic        ordy;
    logic        ov;
    logic [31:0] ed;
    logic        ir;
  } vec_t;
  vec_t tv[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic fl, input logic ordy);
    in_valid = iv;
    in_rd1 = d;
    in_rd2 = ~d;
    in_immed = d + 32'd1;
    in_rs = d[4:0];
    in_rt = d[4:0] ^ 5'h1f;
    in_rd = 5'd3;
    in_shamt = 5'd4;
    in_funct = d[5:0];
    flush = fl;
    out_ready = ordy;
  endtask

  initial begin
    in_ctrl = 8'hFF;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset rd1", out_rd1, 32'd0);
    chk("reset ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("reset bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

    tv[0]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1};
    tv[1]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h22, 1'b1};
    tv[2]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1};
    tv[3]  = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 32'h44, 1'b1};
    tv[4]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1};
    tv[5]  = '{1'b1, 32'h0A, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1};
    tv[6]  = '{1'b1, 32'h0B, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0};
    tv[7]  = '{1'b1, 32'h0D, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0};
    tv[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h0B, 1'b1};
    tv[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h0B, 1'b1};
    tv[10] = '{1'b1, 32'h0A, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1};
    tv[11] = '{1'b1, 32'h0B, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0};
    tv[12] = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 32'h0A, 1'b1};
    tv[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h0A, 1'b1};
    tv[14] = '{1'b1, 32'h0E, 1'b1, 1'b1, 1'b0, 32'h0A, 1'b1};
    tv[15] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h0A, 1'b1};
    for (int i = 0; i < 16; i++) begin
      logic [31:0] e;
      e = tv[i].ed;
      drive(tv[i].iv, tv[i].d, tv[i].fl, tv[i].ordy);
      tick();
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].ov});
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].ir});
      chk($sformatf("v%0d rd1", i), out_rd1, e);
      chk($sformatf("v%0d rd2", i), out_rd2, ~e);
      chk($sformatf("v%0d immed", i), out_immed, e + 32'd1);
      chk($sformatf("v%0d rs", i), {27'd0, out_rs}, {27'd0, e[4:0]});
      chk($sformatf("v%0d rt", i), {27'd0, out_rt}, {27'd0, e[4:0] ^ 5'h1f});
      chk($sformatf("v%0d funct", i), {26'd0, out_funct}, {26'd0, e[5:0]});
      chk($sformatf("v%0d ctrl", i), {24'd0, out_ctrl}, tv[i].ov ? 32'hFF : 32'hC7);
      if (i == 3) chk("stream bubble_cnt", {16'd0, bubble_cnt}, 32'd3);
    end

    drive(1'b0, 32'h0, 1'b0, 1'b1);
    in_ctrl = 8'h18;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gated side effects", {24'd0, out_ctrl & 8'h38}, 32'd0);
    end
    in_ctrl = 8'hFF;

    drive(1'b1, 32'h5A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h5B, 1'b0, 1'b0);
    tick();
    chk("pre-reset full in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst rd1", out_rd1, 32'd0);
    chk("midrst rd2", out_rd2, 32'd0);
    chk("midrst ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("midrst bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("midrst sat cnt", {28'd0, s_cnt}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("midrst no stale", {31'd0, out_valid}, 32'd0);
      if (i == 14) chk("sat cnt 14", {28'd0, s_cnt}, 32'd14);
      if (i == 15) chk("sat cnt 15", {28'd0, s_cnt}, 32'd15);
      if (i == 20) chk("sat cnt hold", {28'd0, s_cnt}, 32'd15);
    end
    chk("wide cnt after idle", {16'd0, bubble_cnt}, 32'd20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised, elastic ID→EX pipeline register for the MIPS-lite core.
- Replaces the fixed always-load ID/EX latch with a valid/ready handshake and a 2-entry skid buffer, so stalls do not combinationally chain back into ID.
- Adds flush for branch and jump squash, and bubble-safe gating of side-effecting control bits.
- Adds a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32, width of RD1, RD2 and immediate.
- REG_AW, 5, register-address width for rs/rt/rd/shamt.
- CTRL_W, 8, packed control bundle width: {RegDst, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, ALUOp[1:0]}.
- CNT_W, 16, bubble-counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID presents a valid instruction.
- in_ready  out  1  register can accept; registered output, never combinational from out_ready.
- in_ctrl  in  CTRL_W  control bundle (bit order as in Parameters, MSB first).
- in_funct  in  6  funct field.
- in_rd1, in_rd2, in_immed  in  DATA_W each  operands and sign-extended immediate.
- in_rs, in_rt, in_rd, in_shamt  in  REG_AW each  register fields (rs added for forwarding).
- flush  in  1  squash all held and incoming instructions.
- out_ready  in  1  EX can consume this cycle.
- out_valid  out  1  EX-side instruction valid.
- out_ctrl  out  CTRL_W  control bundle; MemRead, MemWrite and RegWrite bits are forced 0 when out_valid=0.
- out_funct, out_rd1, out_rd2, out_immed, out_rs, out_rt, out_rd, out_shamt  out  matching widths  held payload.
- bubble_cnt  out  CNT_W  count of cycles with out_valid=0, saturating.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with its own valid bit. State = {main_v, skid_v}: EMPTY=00, ONE=10, FULL=11. State 01 is illegal and must not be reachable.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = ~skid_v, registered. out_valid = main_v.
- EMPTY:
  - push → ONE; main loads the input.
- ONE:
  - push & pop → ONE; main loads the input.
  - push only → FULL; skid loads the input.
  - pop only → EMPTY.
  - neither → hold.
- FULL:
  - pop → ONE; main loads from skid, skid clears.
  - no pop → hold. Push cannot occur because in_ready=0.
- Latency: 1 cycle from push to out_valid when EMPTY, or when ONE with a simultaneous pop. No combinational in→out path.
- Ordering: strictly FIFO. An input never bypasses the skid entry.
- flush (priority below rst, above all else):
  - Next cycle: state EMPTY, in_ready=1.
  - Any push in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed by EX in that cycle.
- Payload registers load only on capture; they are not cleared on flush. Only the valid bits clear, and side-effect control bits are gated by valid.
- rst: state EMPTY, in_ready=1, every payload output 0, out_ctrl=0, bubble_cnt=0, all on the same edge. Reset mid-transfer drops all entries.
- bubble_cnt increments by 1 each cycle with out_valid=0 and rst=0, and saturates at 2^CNT_W−1. flush does not clear it.

Decomposition:
- Shared package mips_pkg holds:
  - CTRL_W and the bit-index constants CTRL_REGDST..CTRL_ALUOP.
  - The DATA_W and REG_AW defaults.
  - A packed struct id_ex_payload_t.
- One sub-module, pipe_skid_entry: a payload register with valid and load enable, instantiated twice.
- Top level holds the state logic, flush handling, gating and counter.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then 4 pushes (rd1=0x11, 0x22, 0x33, 0x44) with out_ready=1 → outputs appear 1 cycle later in order; in_ready stays 1; bubble_cnt=3 (2 reset-release bubbles + 1 fill cycle, per chosen bench timing, checked exactly).
- Backpressure: out_ready=0, push A=0xA, B=0xB → state FULL, in_ready=0 in the cycle after B. Raise out_ready → A then B in consecutive cycles; in_ready returns to 1 one cycle after the first pop.
- Flush while FULL: same as the previous scenario, then flush=1 with in_valid=1 (C=0xC) → next cycle out_valid=0, in_ready=1, C never emerges.
- Bubble gating: hold in_ctrl with MemWrite=1, RegWrite=1 and in_valid=0 → out_ctrl MemWrite and RegWrite bits stay 0.
- Saturation: CNT_W=4, idle 20 cycles → bubble_cnt=15 and holds.
- Reset mid-operation: state FULL, assert rst → next cycle all outputs 0, in_ready=1, and old entries never appear.
